// File: rtl/riscv_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Contents:
//   - funct3 encodings for the load/store access size and sign
//   - byte-enable patterns for byte / half / word accesses
//   - LSU state enum
//   - access_legal(): decides whether an IDLE-cycle request may go to the bus
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // A request is legal only if it is exactly one of load/store, the funct3
    // is defined for that direction (unsigned variants exist only for loads),
    // and the address is naturally aligned to the access size.
    function automatic logic access_legal(input logic       rd,
                                          input logic       wr,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (rd ^ wr) begin
            case (f3)
                F3_B:    ok = 1'b1;
                F3_BU:   ok = rd;
                F3_H:    ok = ~off[0];
                F3_HU:   ok = rd & ~off[0];
                F3_W:    ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load-data extraction.
// Selects the addressed byte or halfword out of the 32-bit read word and
// sign- or zero-extends it according to funct3; words pass through.
// Ports:
//   rdata  in  32  read word from the data bus
//   addr   in  2   low byte-address bits of the access
//   funct3 in  3   access size/sign
//   result out 32  extended load value
module load_align_ext
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Shift the addressed lane down to bit 0, then extend by size/sign.
    always_comb begin
        byte_v = 8'(rdata >> {addr, 3'b000});
        half_v = 16'(rdata >> {addr[1], 4'b0000});
        case (funct3)
            F3_B:    result = {{24{byte_v[7]}}, byte_v};
            F3_BU:   result = {24'd0, byte_v};
            F3_H:    result = {{16{half_v[15]}}, half_v};
            F3_HU:   result = {16'd0, half_v};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit.
// Checks the incoming EX/MEM request, places aligned byte lanes onto a
// req/ready data bus with variable latency, and returns the extended load
// result to MEM/WB. stall_MEM freezes the upstream pipeline registers from
// the cycle the access is accepted until the completion cycle.
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   ALUresult_MEM  in  32  effective byte address
//   data2_MEM      in  32  store data
//   MemRead_MEM    in  1   load request
//   MemWrite_MEM   in  1   store request
//   funct3_MEM     in  3   access size/sign
//   mem_req        out 1   bus request, held until ready or timeout
//   mem_we         out 1   1 = store
//   mem_addr       out 32  word address
//   mem_wdata      out 32  lane-replicated store data
//   mem_be         out 4   byte enables
//   mem_ready      in  1   bus completion strobe
//   mem_rdata      in  32  read word, valid with mem_ready
//   read_data_MEM  out 32  extended load result
//   stall_MEM      out 1   hold upstream registers
//   exc_MEM        out 1   one-cycle pulse on an illegal/misaligned request
//   bus_err_MEM    out 1   one-cycle pulse on bus timeout
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUresult_MEM,
    input  logic [31:0] data2_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [2:0]  funct3_MEM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] read_data_MEM,
    output logic        stall_MEM,
    output logic        exc_MEM,
    output logic        bus_err_MEM
);

    // Counter value seen in the last BUSY cycle before a timeout is declared.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state;
    lsu_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       off_q;
    logic [2:0]       f3_q;
    logic             req_any;
    logic             req_ok;
    logic             start;
    logic             illegal;
    logic             timeout;
    logic [3:0]       be_calc;
    logic [31:0]      wdata_calc;
    logic [31:0]      load_ext;

    load_align_ext u_align (
        .rdata  (mem_rdata),
        .addr   (off_q),
        .funct3 (f3_q),
        .result (load_ext)
    );

    // Request classification; only meaningful while IDLE.
    always_comb begin
        req_any = MemRead_MEM | MemWrite_MEM;
        req_ok  = access_legal(MemRead_MEM, MemWrite_MEM, funct3_MEM, ALUresult_MEM[1:0]);
        start   = (state == IDLE) && req_any && req_ok;
        illegal = (state == IDLE) && req_any && !req_ok;
        timeout = (state == BUSY) && !mem_ready && (cnt == CNT_LAST);
    end

    // Byte-lane placement: data is replicated across lanes so the bus only
    // has to honour the byte enables.
    always_comb begin
        case (funct3_MEM[1:0])
            2'b00: begin
                be_calc    = BE_BYTE << ALUresult_MEM[1:0];
                wdata_calc = {4{data2_MEM[7:0]}};
            end
            2'b01: begin
                be_calc    = BE_HALF << {ALUresult_MEM[1], 1'b0};
                wdata_calc = {2{data2_MEM[15:0]}};
            end
            default: begin
                be_calc    = BE_WORD;
                wdata_calc = data2_MEM;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE always returns to IDLE so the request that is
    // still present on the inputs during DONE is never issued twice.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (mem_ready || timeout) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stall is combinational so the upstream registers already hold in the
    // accept cycle; it drops in DONE so they advance on that edge.
    always_comb begin
        stall_MEM = !reset && (start || (state == BUSY));
    end

    // Bus-side registers, timeout counter, load result and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'd0;
            mem_wdata     <= 32'd0;
            mem_be        <= 4'd0;
            read_data_MEM <= 32'd0;
            exc_MEM       <= 1'b0;
            bus_err_MEM   <= 1'b0;
            cnt           <= '0;
            off_q         <= 2'd0;
            f3_q          <= 3'd0;
        end else begin
            exc_MEM     <= illegal;
            bus_err_MEM <= timeout;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite_MEM;
                        mem_addr  <= {ALUresult_MEM[31:2], 2'b00};
                        mem_be    <= be_calc;
                        mem_wdata <= wdata_calc;
                        off_q     <= ALUresult_MEM[1:0];
                        f3_q      <= funct3_MEM;
                        cnt       <= '0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            read_data_MEM <= load_ext;
                        end
                    end else if (timeout) begin
                        mem_req       <= 1'b0;
                        read_data_MEM <= 32'd0;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Consumer side of the EX/MEM pipeline register: the MEM-stage load/store unit.
- Takes ALUresult_MEM (address), data2_MEM (store data), MemRead_MEM/MemWrite_MEM and funct3_MEM.
- Performs byte-lane alignment, drives a req/ready data-memory bus with variable latency, and returns sign/zero-extended load data for MEM/WB.
- Asserts stall_MEM to freeze upstream pipeline registers (drives their write-enable low) while an access is in flight.

Parameters:
- TIMEOUT_CYCLES, 255: max BUSY cycles waiting for mem_ready before a bus error is declared; range 1..255.
- CNT_W, 8: width of timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-high
- ALUresult_MEM  in  32  effective byte address
- data2_MEM  in  32  store data (rs2)
- MemRead_MEM  in  1  load request
- MemWrite_MEM  in  1  store request
- funct3_MEM  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_req  out  1  bus request, held until ready
- mem_we  out  1  1 = store
- mem_addr  out  32  word address (byte address with [1:0] cleared)
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ready  in  1  bus completion, one cycle
- mem_rdata  in  32  read word, valid with mem_ready
- read_data_MEM  out  32  extended load result to MEM/WB
- stall_MEM  out  1  hold upstream registers
- exc_MEM  out  1  one-cycle pulse: misaligned/illegal access
- bus_err_MEM  out  1  one-cycle pulse: timeout

Behaviour:
- Reset values: every output is 0, state is IDLE, counter is 0.
- Reset asserted mid-access: mem_req drops at that edge. A later mem_ready is ignored.
- FSM states are IDLE, BUSY and DONE.
- IDLE, no request: nothing happens.
- IDLE, MemRead_MEM and MemWrite_MEM both 1: illegal; exc_MEM pulses next cycle, no bus access, no stall.
- IDLE, illegal funct3 (load: 011/110/111; store: anything but 000/001/010): exc_MEM pulse, no access, no stall.
- IDLE, misaligned address (H with addr[0]=1; W with addr[1:0]≠0): exc_MEM pulse, no access, no stall.
- IDLE, valid aligned access:
  - stall_MEM=1 combinationally in the same cycle.
  - Latch addr, be, wdata and we.
  - Go to BUSY with mem_req=1 registered.
- BUSY:
  - stall_MEM=1 and mem_req=1, with bus outputs stable.
  - Counter increments each cycle.
  - mem_ready=1: capture load result into read_data_MEM, drop mem_req, go to DONE.
  - Counter reaches TIMEOUT_CYCLES without ready: drop mem_req, read_data_MEM=0, bus_err_MEM pulses in DONE.
- DONE:
  - stall_MEM=0, so the upstream registers advance at this edge.
  - Go to IDLE unconditionally. The still-present old request is never re-issued.
- Minimum occupancy: 3 cycles per access (IDLE→BUSY→DONE), 2 stalled cycles.
- mem_ready outside BUSY is ignored.
- Store lane rules (off = byte address bits [1:0]):
  - B: be = 0001<<off, wdata = {4{data2[7:0]}}.
  - H: be = 0011<<(2·addr[1]), wdata = {2{data2[15:0]}}.
  - W: be = 1111, wdata = data2.
- Load extraction:
  - B/BU: byte rdata[8·off+:8], sign-extended (B) or zero-extended (BU).
  - H/HU: half rdata[16·addr[1]+:16], sign-extended (H) or zero-extended (HU).
  - W: passthrough.
- read_data_MEM holds its value until the next load completes. Stores leave it unchanged.
- Stores do not sample mem_rdata.

Decomposition:
- Shared package (riscv_pkg):
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - LSU state enum {IDLE,BUSY,DONE}.
  - Byte-enable constants.
- Sub-module load_align_ext: combinational. Inputs are rdata, addr[1:0] and funct3; output is the 32-bit extended result. Reused by verification as a reference model.

Test Plan:
- LW addr 0x100, mem_ready after 2 BUSY cycles, rdata 0xDEADBEEF → mem_addr 0x100, be 1111, read_data_MEM 0xDEADBEEF, stall_MEM high exactly 3 cycles.
- LB addr 0x103, rdata 0x80112233 → read_data 0xFFFFFF80; LBU same → 0x00000080; LH addr 0x102 rdata 0x8001xxxx → 0xFFFF8001.
- SB addr 0x201, data2 0x000000AB → mem_we 1, be 0010, wdata 0xABABABAB, addr 0x200; read_data_MEM unchanged.
- LW addr 0x102, or SH addr 0x5 → exc_MEM one-cycle pulse, mem_req never asserted, stall_MEM 0.
- TIMEOUT_CYCLES=4, mem_ready held 0 → mem_req drops after 4 BUSY cycles, bus_err_MEM pulses, read_data 0, FSM returns to IDLE.
- Reset asserted in the 2nd BUSY cycle, then mem_ready pulses → all outputs 0 next edge, mem_ready ignored, state IDLE.
